sram_like_ram_slave: RTL and testbench

- Responder end of the SRAM-like data interface (req/wr/size/addr/wdata → rdata/addr_ok/data_ok) that the CPU and 2x1 data bridges drive as initiators.
- Backs the interface with a local word-organised RAM and returns responses in order after a fixed latency.
- Accepts up to DEPTH outstanding requests.
- Used as a stand-in data memory for bridge and cache bring-up, and as a conf/uncached target model in simulation.

---
 rtl/sram_like_pkg.sv | 38 +++
 rtl/sram_like_resp_queue.sv | 123 ++++++++++++
 rtl/sram_like_ram_slave.sv | 123 ++++++++++++
 tb/tb_sram_like_ram_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like data interface responder:
// transfer-size encodings, the lane-enable decoder and the alignment check.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Byte-lane enables for a lane-aligned store of the given size at addr[1:0].
    // A reserved size enables no lanes.
    function automatic logic [3:0] size_addr_to_be(input logic [1:0] size,
                                                   input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // True for an access that must not touch memory: a halfword on an odd
    // address, a word off a word boundary, or the reserved size code.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order response queue. Each entry carries a read/write flag, the read
// word and a countdown until it may be answered. Read data arrives one
// cycle after the push (synchronous RAM), so the queue remembers which
// slot is waiting for it and forwards the RAM output if that slot is
// already the head.
module sram_like_resp_queue #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       push_is_read_i,
    input  logic                       pop_i,
    input  logic [31:0]                cap_data_i,
    output logic                       head_ready_o,
    output logic                       head_is_read_o,
    output logic [31:0]                head_rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // The push edge itself counts as the first cycle of latency.
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    logic              valid_q   [DEPTH];
    logic              is_read_q [DEPTH];
    logic [31:0]       rdata_q   [DEPTH];
    logic [CW-1:0]     cnt_q     [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q,  count_d;
    logic              cap_pend_q, cap_pend_d;
    logic [PW-1:0]     cap_ptr_q,  cap_ptr_d;

    // Next-state for pointers, occupancy and the pending read capture.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cap_pend_d = push_i && push_is_read_i;
        cap_ptr_d  = wr_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and capture-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cap_pend_q <= 1'b0;
            cap_ptr_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cap_pend_q <= cap_pend_d;
            cap_ptr_q  <= cap_ptr_d;
        end
    end

    // Entry storage: allocate on push, retire on pop, count down while valid,
    // and drop the RAM word into the slot that requested it last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                is_read_q[i] <= 1'b0;
                rdata_q[i]   <= 32'h0;
                cnt_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && (wr_ptr_q == PW'(i))) begin
                    valid_q[i]   <= 1'b1;
                    is_read_q[i] <= push_is_read_i;
                    cnt_q[i]     <= CNT_INIT;
                end else begin
                    if (pop_i && (rd_ptr_q == PW'(i))) begin
                        valid_q[i] <= 1'b0;
                    end
                    if (valid_q[i] && (cnt_q[i] != '0)) begin
                        cnt_q[i] <= cnt_q[i] - CW'(1);
                    end
                end
                if (cap_pend_q && (cap_ptr_q == PW'(i))) begin
                    rdata_q[i] <= cap_data_i;
                end
            end
        end
    end

    // Head view, forwarding the RAM word while its capture is still in flight.
    always_comb begin
        head_ready_o   = valid_q[rd_ptr_q] && (cnt_q[rd_ptr_q] == '0);
        head_is_read_o = is_read_q[rd_ptr_q];
        if (cap_pend_q && (cap_ptr_q == rd_ptr_q)) begin
            head_rdata_o = cap_data_i;
        end else begin
            head_rdata_o = rdata_q[rd_ptr_q];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sram_like_ram_slave.sv
// Responder for the SRAM-like data interface backed by a local word RAM.
// Accepts one request per cycle while the response queue has room and
// answers in order after a fixed latency. Misaligned or reserved-size
// accesses never write memory but still get a response and raise a sticky
// error flag.
module sram_like_ram_slave
    import sram_like_pkg::*;
#(
    parameter int MEM_AW  = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [1:0]                 data_size,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_wdata,
    output logic [31:0]                data_rdata,
    output logic                       data_addr_ok,
    output logic                       data_data_ok,
    input  logic                       stall,
    output logic                       err,
    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int QW = $clog2(DEPTH) + 1;

    logic [31:0]        mem_q [0:(2**MEM_AW)-1];
    logic [31:0]        ram_rdata_q;

    logic               addr_ok_q, addr_ok_d;
    logic               err_q, err_d;

    logic               accept_s, bad_s, wr_en_s, rd_en_s, pop_s;
    logic [3:0]         be_s;
    logic [MEM_AW-1:0]  widx_s;
    logic               head_ready_s, head_is_read_s;
    logic [31:0]        head_rdata_s;
    logic [QW-1:0]      count_s, count_next_s;
    logic               unused_s;

    // Upper address bits alias the RAM and are deliberately ignored.
    assign unused_s = ^data_addr[31:MEM_AW+2];

    // Request decode: acceptance, lane enables and the RAM access strobes.
    always_comb begin
        accept_s = data_req && addr_ok_q;
        bad_s    = misaligned(data_size, data_addr[1:0]);
        be_s     = size_addr_to_be(data_size, data_addr[1:0]);
        wr_en_s  = accept_s && data_wr && !bad_s;
        rd_en_s  = accept_s && !data_wr;
        pop_s    = head_ready_s && !stall;
        widx_s   = data_addr[MEM_AW+1:2];
    end

    // Next error flag and next acceptance window, taken from the occupancy
    // after this edge so a pop never lets a new request through while full.
    always_comb begin
        err_d = err_q || (accept_s && bad_s);
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_s + QW'(1);
            2'b01:   count_next_s = count_s - QW'(1);
            default: count_next_s = count_s;
        endcase
        addr_ok_d = (count_next_s < QW'(DEPTH));
    end

    // Control registers; addr_ok stays low until the first edge out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            addr_ok_q <= addr_ok_d;
            err_q     <= err_d;
        end
    end

    // Word RAM with per-lane write and registered read; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_s && be_s[b]) begin
                mem_q[widx_s][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
        if (rd_en_s) begin
            ram_rdata_q <= mem_q[widx_s];
        end
    end

    sram_like_resp_queue #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk            (clk),
        .rst_n          (resetn),
        .push_i         (accept_s),
        .push_is_read_i (!data_wr),
        .pop_i          (pop_s),
        .cap_data_i     (ram_rdata_q),
        .head_ready_o   (head_ready_s),
        .head_is_read_o (head_is_read_s),
        .head_rdata_o   (head_rdata_s),
        .count_o        (count_s)
    );

    // Response data: the full captured word for reads, zero otherwise.
    always_comb begin
        if (pop_s && head_is_read_s) begin
            data_rdata = head_rdata_s;
        end else begin
            data_rdata = 32'h0;
        end
    end

    assign data_addr_ok = addr_ok_q;
    assign data_data_ok = pop_s;
    assign err          = err_q;
    assign outstanding  = count_s;

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// Directed bench for sram_like_ram_slave (DEPTH=4, LATENCY=2): a per-cycle
// vector table for latency, lane merging and error handling, followed by
// hand sequences for back-pressure and reset with responses in flight.
module tb_sram_like_ram_slave;

    localparam int MEM_AW  = 10;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        stall;
    logic        err;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_ram_slave #(
        .MEM_AW  (MEM_AW),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .stall        (stall),
        .err          (err),
        .outstanding  (outstanding)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  outs;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic req, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic aok, input logic dok, input logic [31:0] rdata,
                                input logic e, input logic [2:0] outs);
        vec_t v;
        v.req = req; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.aok = aok; v.dok = dok; v.rdata = rdata; v.err = e; v.outs = outs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    task automatic read_in(input logic [31:0] a);
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = a;
        data_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic [31:0] exp_word;

        // Row = one cycle: inputs applied, outputs compared in that same cycle.
        vecs[0]  = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
        vecs[1]  = mk(1'b1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
        vecs[2]  = mk(1'b1, 1'b0, 2'd2, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3'd1);
        vecs[3]  = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 3'd2);
        vecs[4]  = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 3'd1);
        vecs[5]  = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
        vecs[6]  = mk(1'b1, 1'b1, 2'd2, 32'h20, 32'h11223344, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
        vecs[7]  = mk(1'b1, 1'b1, 2'd0, 32'h22, 32'h00AA0000, 1'b1, 1'b0, 32'h0,        1'b0, 3'd1);
        vecs[8]  = mk(1'b1, 1'b0, 2'd2, 32'h20, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 3'd2);
        vecs[9]  = mk(1'b1, 1'b1, 2'd1, 32'h20, 32'h00005566, 1'b1, 1'b1, 32'h0,        1'b0, 3'd2);
        vecs[10] = mk(1'b1, 1'b0, 2'd2, 32'h20, 32'h0,        1'b1, 1'b1, 32'h11AA3344, 1'b0, 3'd2);
        vecs[11] = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 3'd2);
        vecs[12] = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b1, 32'h11AA5566, 1'b0, 3'd1);
        vecs[13] = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
        vecs[14] = mk(1'b1, 1'b0, 2'd2, 32'h12, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
        vecs[15] = mk(1'b1, 1'b1, 2'd2, 32'h12, 32'h12345678, 1'b1, 1'b0, 32'h0,        1'b1, 3'd1);
        vecs[16] = mk(1'b1, 1'b0, 2'd2, 32'h10, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 3'd2);
        vecs[17] = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 3'd2);
        vecs[18] = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 3'd1);
        vecs[19] = mk(1'b0, 1'b0, 2'd2, 32'h00, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 3'd0);

        // Reset state.
        idle_in();
        stall  = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_aok",   32'(data_addr_ok), 32'h0);
        chk("rst_dok",   32'(data_data_ok), 32'h0);
        chk("rst_rdata", data_rdata,        32'h0);
        chk("rst_err",   32'(err),          32'h0);
        chk("rst_outs",  32'(outstanding),  32'h0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // Vector table.
        for (int i = 0; i < 20; i++) begin
            data_req   = vecs[i].req;
            data_wr    = vecs[i].wr;
            data_size  = vecs[i].size;
            data_addr  = vecs[i].addr;
            data_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("row%0d_aok", i),   32'(data_addr_ok), 32'(vecs[i].aok));
            chk($sformatf("row%0d_dok", i),   32'(data_data_ok), 32'(vecs[i].dok));
            chk($sformatf("row%0d_rdata", i), data_rdata,        vecs[i].rdata);
            chk($sformatf("row%0d_err", i),   32'(err),          32'(vecs[i].err));
            chk($sformatf("row%0d_outs", i),  32'(outstanding),  32'(vecs[i].outs));
            next_cycle();
        end
        idle_in();

        // Back-pressure: request held every cycle under stall fills the queue.
        stall = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            read_in((k % 2 == 0) ? 32'h10 : 32'h20);
            @(negedge clk);
            chk($sformatf("stall%0d_dok", c), 32'(data_data_ok), 32'h0);
            if (data_addr_ok) begin
                k++;
            end
            next_cycle();
        end
        idle_in();
        @(negedge clk);
        chk("stall_accepts", 32'(k),           32'd4);
        chk("full_aok",      32'(data_addr_ok), 32'h0);
        chk("full_outs",     32'(outstanding),  32'd4);
        next_cycle();
        stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            exp_word = (j % 2 == 0) ? 32'hDEADBEEF : 32'h11AA5566;
            @(negedge clk);
            chk($sformatf("drain%0d_dok", j),   32'(data_data_ok), 32'h1);
            chk($sformatf("drain%0d_rdata", j), data_rdata,        exp_word);
            chk($sformatf("drain%0d_aok", j),   32'(data_addr_ok), (j == 0) ? 32'h0 : 32'h1);
            next_cycle();
        end
        @(negedge clk);
        chk("drained_dok",  32'(data_data_ok), 32'h0);
        chk("drained_outs", 32'(outstanding),  32'h0);
        next_cycle();

        // Reset with three responses in flight.
        stall = 1'b1;
        read_in(32'h10);
        next_cycle();
        read_in(32'h20);
        next_cycle();
        read_in(32'h10);
        next_cycle();
        idle_in();
        @(negedge clk);
        chk("pre_rst_outs", 32'(outstanding), 32'd3);
        next_cycle();
        resetn = 1'b0;
        stall  = 1'b0;
        @(negedge clk);
        chk("mid_rst_aok",  32'(data_addr_ok), 32'h0);
        chk("mid_rst_dok",  32'(data_data_ok), 32'h0);
        chk("mid_rst_outs", 32'(outstanding),  32'h0);
        chk("mid_rst_err",  32'(err),          32'h0);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_dok", c),  32'(data_data_ok), 32'h0);
            chk($sformatf("post_rst%0d_aok", c),  32'(data_addr_ok), 32'h1);
            chk($sformatf("post_rst%0d_outs", c), 32'(outstanding),  32'h0);
            next_cycle();
        end
        read_in(32'h20);
        next_cycle();
        idle_in();
        @(negedge clk);
        chk("rb_early_dok", 32'(data_data_ok), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rb_dok",   32'(data_data_ok), 32'h1);
        chk("rb_rdata", data_rdata,        32'h11AA5566);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
